// File: rtl/rf_buffer_ctl_if.sv
// Handshake and buffer-RAM bus between the buffer controller and its partners.
// Latency: none, this file only carries wires.
// Backpressure: valid/ready toward the disk side, req/grant toward the memory side.
interface rf_buffer_ctl_if #(parameter int AW = 8);
  logic          start;
  logic          dir;
  logic [AW-1:0] count;

  logic [11:0]   disk_in_data;
  logic          disk_in_valid;
  logic          disk_in_ready;

  logic [11:0]   disk_out_data;
  logic          disk_out_valid;
  logic          disk_out_ready;

  logic          dma_req;
  logic          dma_grant;
  logic [11:0]   dma_in_data;
  logic [11:0]   dma_out_data;

  logic [AW-1:0] ram_a;
  logic [11:0]   ram_di;
  logic [11:0]   ram_do;
  logic          ram_ce_n;
  logic          ram_we_n;

  logic          busy;
  logic          done;

  // Controller side
  modport master (
    input  start, dir, count,
    input  disk_in_data, disk_in_valid, disk_out_ready,
    input  dma_grant, dma_in_data, ram_do,
    output disk_in_ready, disk_out_data, disk_out_valid,
    output dma_req, dma_out_data,
    output ram_a, ram_di, ram_ce_n, ram_we_n,
    output busy, done
  );

  // Disk, memory and RAM side
  modport slave (
    output start, dir, count,
    output disk_in_data, disk_in_valid, disk_out_ready,
    output dma_grant, dma_in_data, ram_do,
    input  disk_in_ready, disk_out_data, disk_out_valid,
    input  dma_req, dma_out_data,
    input  ram_a, ram_di, ram_ce_n, ram_we_n,
    input  busy, done
  );
endinterface

// File: rtl/rf_buffer_ctl.sv
// Buffer controller: fills a 2**AW x 12 RAM from one side, then drains it to the other.
// Latency: start to done is (count+1)*2+3 cycles inclusive when partners are always ready.
// Backpressure: fill/drain pointers hold while the partner withholds valid/ready/grant.
module rf_buffer_ctl #(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  rf_buffer_ctl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_WFLUSH = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_dir;
  logic [AW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_ram_a;
  logic [11:0]   r_ram_di;
  logic          r_ram_we_n;
  logic          r_ram_ce_n;

  logic          w_fill;
  logic          w_drain;
  logic          w_fill_acc;
  logic          w_drain_acc;
  logic [11:0]   w_fill_dat;

  assign w_fill  = (r_state == S_FILL);
  assign w_drain = (r_state == S_DRAIN);

  // Handshake outputs are pure decodes of registered state and the latched
  // direction, so anything not owned by the current state/dir stays 0.
  assign bus.disk_in_ready  = w_fill & ~r_dir;
  assign bus.dma_req        = (w_fill & r_dir) | (w_drain & ~r_dir);
  assign bus.disk_out_valid = w_drain & r_dir;
  assign bus.dma_out_data   = (w_drain & ~r_dir) ? bus.ram_do : 12'd0;
  assign bus.disk_out_data  = (w_drain &  r_dir) ? bus.ram_do : 12'd0;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = (r_state == S_DONE);

  assign bus.ram_a    = r_ram_a;
  assign bus.ram_di   = r_ram_di;
  assign bus.ram_we_n = r_ram_we_n;
  assign bus.ram_ce_n = r_ram_ce_n;

  // A grant or valid only counts when the matching request/ready is up.
  assign w_fill_acc  = w_fill  & (r_dir ? bus.dma_grant      : bus.disk_in_valid);
  assign w_drain_acc = w_drain & (r_dir ? bus.disk_out_ready : bus.dma_grant);
  assign w_fill_dat  = r_dir ? bus.dma_in_data : bus.disk_in_data;

  // Transfer sequencer; RAM strobes are registered so a write occupies the
  // whole cycle after acceptance with address and data held steady.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dir      <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_ram_a    <= '0;
      r_ram_di   <= 12'd0;
      r_ram_we_n <= 1'b1;
      r_ram_ce_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ram_we_n <= 1'b1;
          r_ram_ce_n <= 1'b1;
          if (bus.start) begin
            r_dir   <= bus.dir;
            r_count <= bus.count;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_state <= S_FILL;
          end
        end

        S_FILL: begin
          if (w_fill_acc) begin
            r_ram_a    <= r_wptr;
            r_ram_di   <= w_fill_dat;
            r_ram_we_n <= 1'b0;
            r_ram_ce_n <= 1'b0;
            // Stop on the last word instead of incrementing, so the pointer never wraps.
            if (r_wptr == r_count) begin
              r_state <= S_WFLUSH;
            end else begin
              r_wptr <= r_wptr + 1'b1;
            end
          end else begin
            r_ram_we_n <= 1'b1;
            r_ram_ce_n <= 1'b1;
          end
        end

        S_WFLUSH: begin
          // Final write completes this cycle; line up the first read.
          r_ram_we_n <= 1'b1;
          r_ram_ce_n <= 1'b0;
          r_ram_a    <= '0;
          r_rptr     <= '0;
          r_state    <= S_DRAIN;
        end

        S_DRAIN: begin
          if (w_drain_acc) begin
            if (r_rptr == r_count) begin
              r_ram_ce_n <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_rptr  <= r_rptr + 1'b1;
              r_ram_a <= r_rptr + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_buffer_ctl.sv
// Directed bench for rf_buffer_ctl with a RAM model and disk/memory partners.
// Latency: checks exact start-to-done cycle counts for always-ready partners.
// Backpressure: exercises input gaps, drain stalls, stray start/grant and mid-fill reset.
module tb_rf_buffer_ctl;
  localparam int AW = 8;

  logic clk;
  logic reset;

  rf_buffer_ctl_if #(.AW(AW)) ifc();

  rf_buffer_ctl #(.AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer RAM model: synchronous write, combinational read.
  logic [11:0] mem [0:255];
  logic [7:0]  wa_q [$];
  logic [11:0] wd_q [$];
  assign ifc.ram_do = mem[ifc.ram_a];

  always @(posedge clk) begin
    if (!ifc.ram_ce_n && !ifc.ram_we_n) begin
      mem[ifc.ram_a] <= ifc.ram_di;
      wa_q.push_back(ifc.ram_a);
      wd_q.push_back(ifc.ram_di);
    end
  end

  int          checks;
  int          errors;
  logic [11:0] src [0:255];
  logic [11:0] out_q [$];
  int          done_cyc;
  int          stall_bad;

  // Drives one transfer at negedges and records outputs; the tests do the comparing.
  task automatic run_transfer(input bit d, input int cnt, input int gap_pct,
                              input int stall_len, input int inject_cyc);
    int          cyc;
    int          idx;
    int          stall_left;
    logic [7:0]  s_a;
    logic [11:0] s_d;
    out_q.delete();
    done_cyc  = -1;
    stall_bad = 0;
    idx       = 0;
    s_a       = '0;
    s_d       = '0;
    stall_left = stall_len;
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.dir   = d;
    ifc.count = cnt[7:0];
    cyc = 0;
    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      ifc.start          = 1'b0;
      ifc.dma_grant      = 1'b0;
      ifc.disk_in_valid  = 1'b0;
      ifc.disk_out_ready = 1'b0;
      if (ifc.done) begin
        done_cyc = cyc;
      end else if (cyc == inject_cyc) begin
        // Stray start with different settings plus an unrequested grant.
        ifc.start       = 1'b1;
        ifc.dir         = ~d;
        ifc.count       = 8'd0;
        ifc.dma_grant   = 1'b1;
        ifc.dma_in_data = 12'o5555;
      end else begin
        if (ifc.disk_in_ready && idx <= cnt && $urandom_range(99) >= gap_pct) begin
          ifc.disk_in_valid = 1'b1;
          ifc.disk_in_data  = src[idx];
          idx++;
        end
        if (ifc.dma_req && d && idx <= cnt && $urandom_range(99) >= gap_pct) begin
          ifc.dma_grant   = 1'b1;
          ifc.dma_in_data = src[idx];
          idx++;
        end
        if (ifc.dma_req && !d && $urandom_range(99) >= gap_pct) begin
          ifc.dma_grant = 1'b1;
          out_q.push_back(ifc.dma_out_data);
        end
        if (ifc.disk_out_valid) begin
          if (stall_left > 0) begin
            if (stall_left == stall_len) begin
              s_a = ifc.ram_a;
              s_d = ifc.disk_out_data;
            end else if (ifc.ram_a !== s_a || ifc.disk_out_data !== s_d) begin
              stall_bad++;
            end
            stall_left--;
          end else begin
            ifc.disk_out_ready = 1'b1;
            out_q.push_back(ifc.disk_out_data);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b required 0/0", ifc.busy, ifc.done);
    end
    checks++;
    if (ifc.ram_we_n !== 1'b1 || ifc.ram_ce_n !== 1'b1 || ifc.ram_a !== 8'd0 || ifc.ram_di !== 12'd0) begin
      errors++;
      $display("FAIL reset_ram: we_n=%b ce_n=%b a=%0d di=%o required 1/1/0/0",
               ifc.ram_we_n, ifc.ram_ce_n, ifc.ram_a, ifc.ram_di);
    end
    checks++;
    if (ifc.disk_in_ready !== 1'b0 || ifc.dma_req !== 1'b0 || ifc.disk_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_rdy=%b req=%b out_vld=%b required 0/0/0",
               ifc.disk_in_ready, ifc.dma_req, ifc.disk_out_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_disk_to_mem();
    src[0] = 12'o1111; src[1] = 12'o2222; src[2] = 12'o3333; src[3] = 12'o4444;
    wa_q.delete(); wd_q.delete();
    run_transfer(1'b0, 3, 0, 0, -1);
    checks++;
    if (done_cyc !== 10) begin
      errors++;
      $display("FAIL d2m_latency: done at cycle %0d required 10", done_cyc);
    end
    checks++;
    if (wa_q.size() !== 4) begin
      errors++;
      $display("FAIL d2m_write_count: %0d required 4", wa_q.size());
    end
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== i[7:0] || wd_q[i] !== src[i]) begin
        errors++;
        $display("FAIL d2m_write%0d: a=%0d d=%o required a=%0d d=%o", i, wa_q[i], wd_q[i], i, src[i]);
      end
    end
    checks++;
    if (out_q.size() !== 4) begin
      errors++;
      $display("FAIL d2m_dma_count: %0d required 4", out_q.size());
    end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== src[i]) begin
        errors++;
        $display("FAIL d2m_dma%0d: %o required %o", i, out_q[i], src[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL d2m_after_done: done=%b busy=%b required 0/0", ifc.done, ifc.busy);
    end
  endtask

  task automatic test_mem_to_disk_stall();
    src[0] = 12'o7777;
    wa_q.delete(); wd_q.delete();
    run_transfer(1'b1, 0, 0, 10, -1);
    checks++;
    if (wa_q.size() !== 1 || wa_q[0] !== 8'd0 || wd_q[0] !== 12'o7777) begin
      errors++;
      $display("FAIL m2d_write: n=%0d a=%0d d=%o required n=1 a=0 d=7777",
               wa_q.size(), wa_q[0], wd_q[0]);
    end
    checks++;
    if (out_q.size() !== 1 || out_q[0] !== 12'o7777) begin
      errors++;
      $display("FAIL m2d_disk_out: n=%0d d=%o required n=1 d=7777", out_q.size(), out_q[0]);
    end
    checks++;
    if (stall_bad !== 0) begin
      errors++;
      $display("FAIL m2d_stall_stable: %0d unstable cycles required 0", stall_bad);
    end
    checks++;
    if (done_cyc !== 14) begin
      errors++;
      $display("FAIL m2d_latency: done at cycle %0d required 14", done_cyc);
    end
  endtask

  task automatic test_full_random();
    int bad_w;
    int bad_r;
    for (int i = 0; i < 256; i++) src[i] = 12'($urandom_range(4095));
    wa_q.delete(); wd_q.delete();
    run_transfer(1'b0, 255, 40, 0, -1);
    checks++;
    if (wa_q.size() !== 256 || out_q.size() !== 256) begin
      errors++;
      $display("FAIL full_counts: writes=%0d reads=%0d required 256/256", wa_q.size(), out_q.size());
    end
    bad_w = 0;
    bad_r = 0;
    for (int i = 0; i < 256 && i < wa_q.size(); i++)
      if (wa_q[i] !== i[7:0] || wd_q[i] !== src[i]) bad_w++;
    for (int i = 0; i < 256 && i < out_q.size(); i++)
      if (out_q[i] !== src[i]) bad_r++;
    checks++;
    if (bad_w !== 0) begin
      errors++;
      $display("FAIL full_writes: %0d wrong writes required 0", bad_w);
    end
    checks++;
    if (bad_r !== 0) begin
      errors++;
      $display("FAIL full_reads: %0d wrong reads required 0", bad_r);
    end
    checks++;
    if (done_cyc < 514) begin
      errors++;
      $display("FAIL full_done: done at cycle %0d required >= 514", done_cyc);
    end
  endtask

  task automatic test_start_ignored();
    src[0] = 12'o0101; src[1] = 12'o0202; src[2] = 12'o0303; src[3] = 12'o0404;
    wa_q.delete(); wd_q.delete();
    run_transfer(1'b0, 3, 0, 0, 2);
    checks++;
    if (wa_q.size() !== 4 || wd_q[0] !== 12'o0101 || wd_q[1] !== 12'o0202) begin
      errors++;
      $display("FAIL ign_writes: n=%0d d0=%o d1=%o required 4/0101/0202", wa_q.size(), wd_q[0], wd_q[1]);
    end
    checks++;
    if (out_q.size() !== 4 || out_q[3] !== 12'o0404) begin
      errors++;
      $display("FAIL ign_reads: n=%0d last=%o required 4/0404", out_q.size(), out_q[3]);
    end
    checks++;
    if (done_cyc !== 11) begin
      errors++;
      $display("FAIL ign_latency: done at cycle %0d required 11", done_cyc);
    end
  endtask

  task automatic test_reset_mid_fill();
    wa_q.delete(); wd_q.delete();
    @(negedge clk);
    ifc.start = 1'b1; ifc.dir = 1'b0; ifc.count = 8'd9;
    @(negedge clk);
    ifc.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ifc.disk_in_valid = 1'b1;
      ifc.disk_in_data  = 12'(k + 1);
      @(negedge clk);
    end
    ifc.disk_in_valid = 1'b0;
    checks++;
    if (ifc.ram_we_n !== 1'b0 || ifc.ram_a !== 8'd4) begin
      errors++;
      $display("FAIL rst_pre: we_n=%b a=%0d required 0/4", ifc.ram_we_n, ifc.ram_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.ram_we_n !== 1'b1 || ifc.busy !== 1'b0 || ifc.disk_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: we_n=%b busy=%b in_rdy=%b required 1/0/0",
               ifc.ram_we_n, ifc.busy, ifc.disk_in_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (wa_q.size() !== 4) begin
      errors++;
      $display("FAIL rst_no_write: %0d writes required 4", wa_q.size());
    end
    src[0] = 12'o1234; src[1] = 12'o4321;
    wa_q.delete(); wd_q.delete();
    run_transfer(1'b0, 1, 0, 0, -1);
    checks++;
    if (wa_q.size() !== 2 || wa_q[0] !== 8'd0 || wd_q[0] !== 12'o1234) begin
      errors++;
      $display("FAIL rst_restart: n=%0d a=%0d d=%o required 2/0/1234", wa_q.size(), wa_q[0], wd_q[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ifc.start = 1'b0; ifc.dir = 1'b0; ifc.count = '0;
    ifc.disk_in_data = '0; ifc.disk_in_valid = 1'b0; ifc.disk_out_ready = 1'b0;
    ifc.dma_grant = 1'b0; ifc.dma_in_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_disk_to_mem();
    test_mem_to_disk_stall();
    test_full_random();
    test_start_ignored();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_buffer_ctl.md
RF_BUFFER_CTL -- requirements
Module: rf_buffer_ctl

Interface
REQ-001 Parameter: AW, default 8, buffer address width (buffer depth 2**AW words of 12 bits).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-004 start  in  1  one-cycle pulse; begins a transfer, sampled only in IDLE.
REQ-005 dir  in  1  0 = disk->buffer->memory; 1 = memory->buffer->disk; sampled with start.
REQ-006 count  in  AW  word count minus one (0 -> 1 word, 255 -> 256 words); sampled with start.
REQ-007 disk_in_data  in  12  word from disk side.
REQ-008 disk_in_valid  in  1  disk_in_data valid.
REQ-009 disk_in_ready  out  1  controller accepts a disk word this cycle.
REQ-010 disk_out_data  out  12  word to disk side.
REQ-011 disk_out_valid  out  1  disk_out_data valid.
REQ-012 disk_out_ready  in  1  disk side accepts a word this cycle.
REQ-013 dma_req  out  1  data-break request; held until grant.
REQ-014 dma_grant  in  1  one-cycle pulse; completes one word transfer.
REQ-015 dma_in_data  in  12  memory word; sampled on dma_grant in FILL.
REQ-016 dma_out_data  out  12  word to memory; valid while dma_req in DRAIN.
REQ-017 ram_a  out  AW  buffer RAM address.
REQ-018 ram_di  out  12  buffer RAM write data.
REQ-019 ram_do  in  12  buffer RAM read data, combinational from ram_a.
REQ-020 ram_ce_n  out  1  RAM chip enable, active-low.
REQ-021 ram_we_n  out  1  RAM write enable, active-low.
REQ-022 busy  out  1  high in any state except IDLE.
REQ-023 done  out  1  one-cycle pulse at transfer completion.

Function
REQ-024 States SHALL be IDLE, FILL, WFLUSH, DRAIN, DONE.
REQ-025 IDLE + start: latch dir and count, clear wptr and rptr, go to FILL next cycle; start outside IDLE SHALL be ignored.
REQ-026 FILL source SHALL be the disk stream when dir=0 (disk_in_ready=1, accept on disk_in_valid&disk_in_ready) and DMA when dir=1 (dma_req=1, accept on dma_grant).
REQ-027 Each accepted word SHALL be registered into ram_di with ram_a=wptr, and ram_we_n=0 with ram_ce_n=0 SHALL be asserted for exactly the following cycle.
REQ-028 Write pipelining: one word per cycle SHALL be sustained; ram_a/ram_di SHALL stay stable throughout the ram_we_n=0 cycle.
REQ-029 Accepting the word with wptr==count SHALL move FILL to WFLUSH; otherwise wptr increments by 1.
REQ-030 WFLUSH SHALL last one cycle, completing the final write, then go to DRAIN with rptr=0.
REQ-031 In DRAIN, ram_a=rptr, ram_ce_n=0, ram_we_n=1; dir=0 drives dma_out_data=ram_do with dma_req=1, and dir=1 drives disk_out_data=ram_do with disk_out_valid=1.
REQ-032 A DRAIN word SHALL complete on dma_grant (dir=0) or disk_out_valid&disk_out_ready (dir=1); rptr==count at completion moves to DONE, otherwise rptr increments.
REQ-033 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-034 Handshake outputs not named for the current state/dir SHALL be 0; a grant or valid arriving when not requested SHALL be ignored.
REQ-035 count=255 SHALL transfer 256 words; address counters SHALL never wrap within a transfer.
REQ-036 Worst-case latency from start to done, with partner always ready, SHALL be (count+1)*2+3 cycles.

Reset
REQ-037 On reset: state=IDLE, wptr=rptr=0, ram_we_n=1, ram_ce_n=1, ram_a=0, ram_di=0, all valid/ready/req outputs 0, busy=0, done=0.
REQ-038 Reset mid-transfer SHALL abort immediately with no further RAM write; a RAM write cycle in progress SHALL be terminated.

Verification
REQ-039 dir=0, count=3, disk words 0o1111,0o2222,0o3333,0o4444 back-to-back -> 4 RAM writes at addresses 0..3; dma_out_data sequence 0o1111..0o4444 on 4 grants; done after 4th grant.
REQ-040 dir=1, count=0, one dma_grant with 0o7777 -> one write to address 0; disk_out_data=0o7777 held with disk_out_valid until disk_out_ready; then done pulse.
REQ-041 dir=0, count=255, random disk_in_valid gaps -> 256 writes to addresses 0..255 in order; no write lost or duplicated; 256 DMA reads in order.
REQ-042 disk_out_ready held low 10 cycles in DRAIN -> disk_out_data and ram_a stable; rptr unchanged.
REQ-043 start pulsed during FILL -> ignored; count/dir unchanged; transfer completes normally.
REQ-044 reset asserted mid-FILL at wptr=5 -> same cycle: ram_we_n=1, busy=0; next start begins at address 0.
